// File: rtl/channel_mem_reader.sv
// Purpose : read-side sequencer; streams len words from channel memory address 0, rep times, onto a valid/ready stream.
// Latency : start in cycle 0 -> CLR cycle 1, first issue cycle 2, first out_valid cycle 4; 1 word/cycle sustained, one bubble per pass wrap.
// Backpr. : issue is credit-gated against a 2-entry registered-output FIFO, so a stalled consumer never loses or duplicates a word.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, len, rep             run request; len/rep latched when start is accepted in IDLE
//   busy, done                  run in progress / one-cycle completion pulse
//   mem_rd_en/inc/clr           channel memory read controls
//   mem_data_in                 channel memory read data (valid the cycle after an issue)
//   out_valid/ready/data/last   output stream; out_last marks the final word of each pass
module channel_mem_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADD_WIDTH  = 10,
    parameter int LEN_WIDTH  = ADD_WIDTH + 1,
    parameter int REP_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [REP_WIDTH-1:0]  rep,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic                  mem_rd_inc,
    output logic                  mem_rd_clr,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLR    = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_WRAP   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] dat;
    } word_t;

    logic [2:0]           state;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] word_cnt;
    logic [REP_WIDTH-1:0] rep_q;
    logic [REP_WIDTH-1:0] pass_cnt;
    logic                 inflight;
    logic                 inflight_last;
    logic                 done_q;
    logic                 busy_q;

    logic [1:0]           fifo_cnt;
    word_t                fifo_q0;   // head entry, drives the stream outputs directly
    word_t                fifo_q1;

    logic                 pop;
    logic                 push;
    word_t                push_w;
    logic [2:0]           occ;
    logic                 issue;
    logic                 last_word;
    logic                 last_pass;

    always_comb begin
        pop       = (fifo_cnt != 2'd0) && out_ready;
        push      = inflight;
        push_w    = '{last: inflight_last, dat: mem_data_in};
        // Slots committed after this cycle: stored words plus the word in flight, minus the one leaving.
        occ       = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
        issue     = (state == S_STREAM) && (occ < 3'd2);
        last_word = (word_cnt == (len_q - LEN_WIDTH'(1)));
        last_pass = (pass_cnt == (rep_q - REP_WIDTH'(1)));
    end

    // Every state that can follow an issue keeps mem_rd_en high so the read data is presented for capture.
    always_comb begin
        mem_rd_en  = (state == S_STREAM) || (state == S_WRAP) || (state == S_DRAIN);
        mem_rd_clr = (state == S_CLR) || (state == S_WRAP);
        mem_rd_inc = issue;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            len_q    <= '0;
            rep_q    <= '0;
            word_cnt <= '0;
            pass_cnt <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (done_q) begin
                busy_q <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if ((len != '0) && (rep != '0)) begin
                            len_q  <= len;
                            rep_q  <= rep;
                            busy_q <= 1'b1;
                            state  <= S_CLR;
                        end else begin
                            // Empty request: acknowledge without touching the memory.
                            done_q <= 1'b1;
                        end
                    end
                end
                S_CLR: begin
                    word_cnt <= '0;
                    pass_cnt <= '0;
                    state    <= S_STREAM;
                end
                S_STREAM: begin
                    if (issue) begin
                        if (last_word) begin
                            word_cnt <= '0;
                            state    <= last_pass ? S_DRAIN : S_WRAP;
                        end else begin
                            word_cnt <= word_cnt + LEN_WIDTH'(1);
                        end
                    end
                end
                S_WRAP: begin
                    pass_cnt <= pass_cnt + REP_WIDTH'(1);
                    word_cnt <= '0;
                    state    <= S_STREAM;
                end
                S_DRAIN: begin
                    // Finish in the cycle the last word leaves, so done lands one cycle after its handshake.
                    if (!inflight && (fifo_cnt == {1'b0, pop})) begin
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && last_word;
        end
    end

    // Two-entry FIFO with the head held in a register; the credit check keeps pushes off a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_cnt <= 2'd0;
            fifo_q0  <= '0;
            fifo_q1  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (fifo_cnt == 2'd0) begin
                        fifo_q0 <= push_w;
                    end else begin
                        fifo_q1 <= push_w;
                    end
                    fifo_cnt <= fifo_cnt + 2'd1;
                end
                2'b01: begin
                    fifo_q0  <= fifo_q1;
                    fifo_cnt <= fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd1) begin
                        fifo_q0 <= push_w;
                    end else begin
                        fifo_q0 <= fifo_q1;
                        fifo_q1 <= push_w;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_valid = (fifo_cnt != 2'd0);
    assign out_data  = fifo_q0.dat;
    assign out_last  = fifo_q0.last && out_valid;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_channel_mem_reader.sv
module tb_channel_mem_reader;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int LW = AW + 1;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic [RW-1:0] rep = '0;
    logic          busy, done;
    logic          mem_rd_en, mem_rd_inc, mem_rd_clr;
    logic [DW-1:0] mem_data_in;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last;

    channel_mem_reader #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .LEN_WIDTH(LW), .REP_WIDTH(RW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .rep(rep),
        .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_rd_inc(mem_rd_inc), .mem_rd_clr(mem_rd_clr),
        .mem_data_in(mem_data_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Channel memory model: registered read, pointer clear has priority, data driven only while enabled.
    logic [DW-1:0] mem_arr [0:(1<<AW)-1];
    logic [AW-1:0] mem_ptr = '0;
    logic [DW-1:0] mem_rreg = '0;
    always @(posedge clk) begin
        if (mem_rd_clr) begin
            mem_ptr <= '0;
        end else if (mem_rd_en) begin
            mem_rreg <= mem_arr[mem_ptr];
            mem_ptr  <= mem_ptr + AW'(mem_rd_inc);
        end
    end
    assign mem_data_in = mem_rd_en ? mem_rreg : '0;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;
    exp_t exp_q[$];

    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   last_hs_cyc = -1;
    int   first_vld_cyc = -1;
    int   rdy_mode = 0;
    logic stall_prev = 1'b0;
    logic [DW-1:0] stall_dat = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Ready driver: always ready, or a coin flip each cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Compare process: every handshake is checked against the expected word list.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stall_prev) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_data", 32'(out_data), 32'(stall_dat));
                end
                if (out_valid && out_ready) begin
                    chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("data", 32'(out_data), 32'(e.d));
                        chk("last", 32'(out_last), 32'(e.l));
                    end
                    last_hs_cyc = cyc;
                end
                if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
                if (done) done_cnt++;
                stall_prev = out_valid && !out_ready;
                stall_dat  = out_data;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic load_exp(input int n, input int r);
        exp_t e;
        exp_q.delete();
        for (int rr = 0; rr < r; rr++) begin
            for (int w = 0; w < n; w++) begin
                e.d = mem_arr[w];
                e.l = (w == n - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run(input int n, input int r, input int mode, output int done_off);
        int t0, dc0, got, dcyc;
        load_exp(n, r);
        rdy_mode = mode;
        dc0 = done_cnt;
        done_off = -1;
        @(posedge clk); #1;
        first_vld_cyc = -1;
        start = 1'b1; len = LW'(n); rep = RW'(r); t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0; len = LW'($urandom); rep = RW'($urandom);
        got = 0;
        for (int i = 0; i < n * r * 6 + 60; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        if (got != 0) begin
            dcyc = cyc;
            done_off = dcyc - t0;
            chk("busy_at_done", 32'(busy), 32'd1);
            chk("done_after_last_hs", 32'(dcyc - last_hs_cyc), 32'd1);
            if (mode == 0) begin
                chk("first_valid_latency", 32'(first_vld_cyc - t0), 32'd4);
                chk("done_latency", 32'(done_off), 32'(4 + r * n + r - 1));
            end
            @(negedge clk);
            chk("busy_after_done", 32'(busy), 32'd0);
            chk("done_one_cycle", 32'(done), 32'd0);
        end
        repeat (2) @(negedge clk);
        chk("words_remaining", 32'(exp_q.size()), 32'd0);
        chk("done_count", 32'(done_cnt - dc0), 32'd1);
        exp_q.delete();
        rdy_mode = 0;
    endtask

    task automatic zero_run(input int n, input int r);
        int t0;
        @(posedge clk); #1;
        start = 1'b1; len = LW'(n); rep = RW'(r); t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("zero_done", 32'(done), (cyc == t0 + 1) ? 32'd1 : 32'd0);
            chk("zero_mem_ctrl", 32'({mem_rd_en, mem_rd_inc, mem_rd_clr}), 32'd0);
            chk("zero_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int off, n, r, dc0;
        for (int i = 0; i < (1 << AW); i++) mem_arr[i] = DW'(i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_ctrl", 32'({mem_rd_en, mem_rd_inc, mem_rd_clr}), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run(8, 1, 0, off);
        chk("t1_done_cycle", 32'(off), 32'd12);
        run(4, 3, 0, off);
        chk("t2_done_cycle", 32'(off), 32'd18);
        run(8, 1, 1, off);
        run(8, 2, 1, off);

        for (int i = 0; i < (1 << AW); i++) mem_arr[i] = DW'($urandom);
        run(1024, 1, 0, off);
        chk("t1024_done_cycle", 32'(off), 32'd1028);
        run(1, 1, 0, off);
        run(1, 3, 1, off);

        zero_run(0, 3);
        zero_run(5, 0);

        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 24);
            r = $urandom_range(1, 4);
            run(n, r, int'($urandom_range(0, 1)), off);
        end

        // Reset in the middle of pass 2, then a fresh run must start over at word 0.
        load_exp(6, 2);
        dc0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; len = LW'(6); rep = RW'(2);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_mem_ctrl", 32'({mem_rd_en, mem_rd_inc, mem_rd_clr}), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("arst_no_done", 32'(done_cnt - dc0), 32'd0);
        chk("arst_idle_valid", 32'(out_valid), 32'd0);
        run(6, 2, 0, off);
        chk("post_rst_done_cycle", 32'(off), 32'd17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
